// File: rtl/router_pkg.sv
// Router-wide shared types: the per-port global state reported by each output unit.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    WAITING = 2'd2,
    ACTIVE  = 2'd3
  } GLOBAL_STATE_t;

endpackage

// File: rtl/output_port_arbiter.sv
// Per-output-port round-robin switch arbiter with packet-level grant lock and credit gating.
// Optional OUT_ARB_BACK2BACK_EN: pick the next winner in the tail cycle, removing the bubble.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter  int NUM_INPUTS = 5,
  parameter  int CREDITS    = 4,
  localparam int CW         = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [NUM_INPUTS-1:0] i_tail,
  input  logic                  i_credit_ret,
  output logic [NUM_INPUTS-1:0] o_grant,
  output logic                  o_send,
  output logic [CW-1:0]         o_credits,
  output GLOBAL_STATE_t         o_gstate,
  output logic                  o_credit_err
);

  localparam int PW = $clog2(NUM_INPUTS);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_WAITING = WAITING;
  localparam logic [1:0] S_ACTIVE  = ACTIVE;

  logic [1:0]            state_q,   state_d;
  logic [NUM_INPUTS-1:0] grant_q,   grant_d;
  logic [PW-1:0]         rr_ptr_q,  rr_ptr_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  err_q,     err_d;

  logic [PW-1:0]         owner_idx;
  logic [PW-1:0]         owner_nxt;
  logic                  owner_req;
  logic                  owner_tail;
  logic                  send;

  // First requester at or after start, wrapping modulo NUM_INPUTS.
  function automatic logic [NUM_INPUTS-1:0] rr_pick(
    input logic [NUM_INPUTS-1:0] req,
    input logic [PW-1:0]         start
  );
    logic [NUM_INPUTS-1:0] gnt;
    logic                  found;
    int                    idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_INPUTS) idx -= NUM_INPUTS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  assign owner_nxt  = (owner_idx == PW'(NUM_INPUTS - 1)) ? '0 : owner_idx + PW'(1);
  assign owner_req  = |(i_req & grant_q);
  assign owner_tail = |(i_tail & i_req & grant_q);
  assign send       = (state_q == S_ACTIVE) && owner_req && (credits_q != '0);

`ifdef OUT_ARB_BACK2BACK_EN
  logic [NUM_INPUTS-1:0] next_req;
  assign next_req = i_req & ~grant_q;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          grant_d = rr_pick(i_req, rr_ptr_q);
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (send && owner_tail) begin
          rr_ptr_d = owner_nxt;
`ifdef OUT_ARB_BACK2BACK_EN
          if (|next_req) begin
            grant_d = rr_pick(next_req, owner_nxt);
            state_d = S_ACTIVE;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
`else
          grant_d = '0;
          state_d = S_IDLE;
`endif
        end else if (owner_req && (credits_q == '0)) begin
          state_d = S_WAITING;
        end
      end
      S_WAITING: begin
        if (credits_q != '0) state_d = S_ACTIVE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // A return with no send while already full is dropped and flagged rather than wrapping.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({send, i_credit_ret})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(CREDITS)) err_d = 1'b1;
        else                           credits_d = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      credits_q <= CW'(CREDITS);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_send       = send;
  assign o_credits    = credits_q;
  assign o_gstate     = GLOBAL_STATE_t'(state_q);
  assign o_credit_err = err_q;

endmodule
